mix_columns_serial: RTL
=======================

# mix_columns_serial

Forward AES MixColumns unit for the encryption datapath, the counterpart of the decryption-side inverse MixColumns stage. It accepts one 128-bit state per valid/ready handshake and processes it column-serially, COLS_PER_CYCLE columns per clock, in a single in-place working register. It presents the result on a held valid/ready output. A bypass flag passes the state through unchanged for the final AES round, which has no MixColumns, while keeping identical latency.

## Interface
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4 (elaboration error otherwise)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- IN_VALID  in  1  IN_DATA/IN_BYPASS valid
- IN_READY  out  1  block can accept; transfer when IN_VALID && IN_READY at a rising edge
- IN_DATA  in  128  state; column c = bits [127-32c -: 32], row 0 in the MSB byte of each column
- IN_BYPASS  in  1  1 = pass the state unchanged (final round)
- OUT_VALID  out  1  MIXED_DATA valid
- OUT_READY  in  1  downstream accepts; transfer when OUT_VALID && OUT_READY
- MIXED_DATA  out  128  result, same byte layout as IN_DATA

## Operation
- Per column (b0..b3 → r0..r3): r0=2b0^3b1^b2^b3, r1=b0^2b1^3b2^b3, r2=b0^b1^2b2^3b3, r3=3b0^b1^b2^2b3, all in GF(2^8). Multiplication by 2 is a left shift, XORed with 0x1b when b[7]=1, truncated to 8 bits.
- States:
  - IDLE: IN_READY=1. On accept, load IN_DATA into the working register, latch IN_BYPASS, clear the column counter, and go to BUSY.
  - BUSY: each cycle, overwrite columns cnt..cnt+COLS_PER_CYCLE-1 with their mixed value, or leave them unchanged if bypass is set. Then cnt += COLS_PER_CYCLE. When the last column is written, go to DONE.
  - DONE: OUT_VALID=1. MIXED_DATA is the working register.
    - OUT_READY=0: stay in DONE with all outputs held stable.
    - OUT_READY=1 and IN_VALID=0: go to IDLE.
    - OUT_READY=1 and IN_VALID=1: the output transfer and the new input accept occur on the same edge. Go directly to BUSY with new data.
- IN_READY = rst_n && (state==IDLE || (state==DONE && OUT_READY)). It is combinational; OUT_READY→IN_READY is the only combinational path through the block.
- Counter width is 2 bits and is not used for COLS_PER_CYCLE=4. The counter wraps to 0 on the last column, never beyond column 3.
- IN_DATA changes while not accepted are ignored. The IN_BYPASS value is captured only at accept.

## Timing
- Reset (rst_n=0 at an edge): state←IDLE, cnt←0, OUT_VALID←0, MIXED_DATA←0, bypass flag←0. IN_READY=0 while rst_n=0.
- Reset mid-operation (BUSY or DONE) aborts the block: no OUT_VALID pulse, and the partial data is cleared.
- Latency: acceptance edge t0 → OUT_VALID high after edge t0+4/COLS_PER_CYCLE. That is 4, 2 or 1 cycles, and is identical with bypass.
- Throughput: one block per 4/COLS_PER_CYCLE+1 cycles with OUT_READY held 1, due to the DONE→BUSY overlap. Example: COLS_PER_CYCLE=1 gives 5 cycles.
- OUT_VALID, once high, never drops without a transfer except on reset.

## Structure
- Shared package aes_pkg: xtime()/gf_mul2/gf_mul3 functions, constant AES_POLY=8'h1b, column slice helper, state enum {IDLE, BUSY, DONE}.
- Sub-module mix_single_column: combinational 32-bit→32-bit mix, generate-instantiated COLS_PER_CYCLE times. The column mux is indexed by cnt.

## Test plan
- FIPS-197 columns: IN_DATA=db135345_f20a225c_01010101_c6c6c6c6 → MIXED_DATA=8e4da1bc_9fdc589d_01010101_c6c6c6c6, OUT_VALID exactly 4 cycles after accept (COLS_PER_CYCLE=1).
- Bypass: IN_DATA=d4d4d4d5_2d26314c_…, IN_BYPASS=1 → output equals input, same latency. The same data with bypass=0 gives d5d5d7d6_4d7ebdf8_….
- Backpressure: OUT_READY=0 for 10 cycles in DONE → OUT_VALID and MIXED_DATA stable, IN_READY=0, and a pending IN_VALID is not accepted.
- Back-to-back: IN_VALID and OUT_READY tied 1, 8 random blocks → every result matches the software model and blocks arrive 5 cycles apart.
- Reset mid-BUSY at cycle 2 → no OUT_VALID. After release, IN_READY=1 and the next block is correct.
- Parameter sweep: COLS_PER_CYCLE=2 and 4 with the vector from scenario 1 → latency 2 and 1 respectively, same MIXED_DATA.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES GF(2^8) helpers and MixColumns FSM state type
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Column c occupies bits [127-32c -: 32], row 0 in its MSB byte
    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
        return s[127 - 32*int'(c) -: 32];
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// rtl/mix_single_column.sv - combinational MixColumns transform of one 32-bit column
module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    logic [7:0] b0, b1, b2, b3;

    assign {b0, b1, b2, b3} = col;

    assign mixed[31:24] = gf_mul2(b0) ^ gf_mul3(b1) ^ b2          ^ b3;
    assign mixed[23:16] = b0          ^ gf_mul2(b1) ^ gf_mul3(b2) ^ b3;
    assign mixed[15:8]  = b0          ^ b1          ^ gf_mul2(b2) ^ gf_mul3(b3);
    assign mixed[7:0]   = gf_mul3(b0) ^ b1          ^ b2          ^ gf_mul2(b3);

endmodule

// File: rtl/mix_columns_serial.sv
// rtl/mix_columns_serial.sv - column-serial forward AES MixColumns with final-round bypass
module mix_columns_serial
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN_DATA,
    input  logic         IN_BYPASS,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] MIXED_DATA
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_serial: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    mc_state_t    state, state_next;
    logic [127:0] work, work_next;
    logic [1:0]   cnt;
    logic         bypass;
    logic         accept;
    logic         last_col;

    logic [1:0]   col_idx [COLS_PER_CYCLE];
    logic [31:0]  col_in  [COLS_PER_CYCLE];
    logic [31:0]  col_out [COLS_PER_CYCLE];

    // With four columns per cycle the 2-bit step truncates to 0, so cnt stays 0
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx[g] = cnt + 2'(g);
        assign col_in[g]  = get_col(work, col_idx[g]);
        mix_single_column u_mix (
            .col   (col_in[g]),
            .mixed (col_out[g])
        );
    end

    assign IN_READY   = rst_n && (state == IDLE || (state == DONE && OUT_READY));
    assign accept     = IN_VALID && IN_READY;
    assign last_col   = (cnt == LAST_CNT);
    assign OUT_VALID  = (state == DONE);
    assign MIXED_DATA = work;

    always_comb begin
        work_next = work;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            work_next[127 - 32*int'(col_idx[g]) -: 32] = bypass ? col_in[g] : col_out[g];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (last_col) state_next = DONE;
            DONE:    if (OUT_READY) state_next = IN_VALID ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            bypass <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                work   <= IN_DATA;
                bypass <= IN_BYPASS;
                cnt    <= '0;
            end else if (state == BUSY) begin
                work <= work_next;
                cnt  <= cnt + STEP;
            end
        end
    end

endmodule
